// File: rtl/nios_mem_pkg.sv
// Shared encodings for the Nios II instruction memory controller:
// FSM states, fetch fault codes and the nop instruction word.
package nios_mem_pkg;

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] FLT_OK       = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_RANGE    = 2'b10;

  // Nios II "add r0, r0, r0", returned in place of any faulting fetch.
  localparam logic [31:0] NIOS_NOP = 32'h0001883A;

endpackage

// File: rtl/instr_mem_array.sv
// Word-organised RAM of four byte lanes. One 32-bit little-endian write port
// (lane 0 holds the lowest byte address) and one registered 32-bit read port.
// The storage has no reset, so loaded code survives a controller reset.
module instr_mem_array #(
  parameter int WORDS = 64,
  parameter int IDX_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [3:0][7:0] mem [WORDS];

  // Write port: lane b takes wr_data[8b+7:8b], i.e. byte address 4*idx+b.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        mem[wr_idx][b] <= wr_data[8*b +: 8];
      end
    end
  end

  // Read port: register the addressed word only on a read, so it holds otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/instr_mem_ctrl.sv
// Clocked instruction memory for the Nios II fetch stage. After reset it sits
// in LOAD, taking word writes from the loader. On ld_done it moves to RUN and
// serves valid/ready fetches with a fixed READ_LAT-cycle response latency,
// reporting misaligned and out-of-range fetches.
module instr_mem_ctrl
  import nios_mem_pkg::*;
#(
  parameter int          DEPTH_BYTES = 256,
  parameter int          ADDR_W      = 32,
  parameter int          READ_LAT    = 1,
  parameter logic [31:0] NOP_WORD    = NIOS_NOP
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_done,
  input  logic              ld_start,
  output logic              ld_err,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic              rsp_valid,
  output logic [31:0]       rsp_inst,
  output logic [1:0]        rsp_fault,
  output logic              busy
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [ADDR_W-1:0] LD_MAX = ADDR_W'(DEPTH_BYTES - 4);
  localparam logic [ADDR_W-1:0] PC_LIM = ADDR_W'(DEPTH_BYTES);

  // Misalignment outranks range; comparisons are full width so nothing wraps.
  function automatic logic [1:0] fetch_fault(input logic [ADDR_W-1:0] a);
    if (a[1:0] != 2'b00) return FLT_MISALIGN;
    if (a >= PC_LIM)     return FLT_RANGE;
    return FLT_OK;
  endfunction

  state_e      state, state_nx;
  logic        pend_start, pend_start_nx;
  logic        accept;
  logic        inflight;
  logic        vld_tail;
  logic        ld_bad;
  logic        wr_ok;
  logic        vld_p0;
  logic [1:0]  flt_p0;
  logic [31:0] rd_data_p0;
  logic [31:0] inst_p0;

  assign accept   = fetch_valid && fetch_ready;
  assign inflight = vld_p0 || vld_tail;

  // A write is legal only in LOAD at an aligned in-range address. ld_en with
  // ld_done still writes but is flagged, and any ld_en in RUN is dropped.
  assign wr_ok  = ld_en && (state == ST_LOAD) && (ld_addr[1:0] == 2'b00)
                  && (ld_addr <= LD_MAX);
  assign ld_bad = ld_en && ((state == ST_RUN) || (ld_addr[1:0] != 2'b00)
                  || (ld_addr > LD_MAX) || ld_done);

  // FSM state and pending re-load request registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_LOAD;
      pend_start <= 1'b0;
    end else begin
      state      <= state_nx;
      pend_start <= pend_start_nx;
    end
  end

  // Next state: a re-load waits until nothing is in flight or being accepted.
  always_comb begin
    state_nx      = state;
    pend_start_nx = pend_start;
    unique case (state)
      ST_LOAD: begin
        pend_start_nx = 1'b0;
        if (ld_done && !ld_en) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if ((ld_start || pend_start) && !inflight && !accept) begin
          state_nx      = ST_LOAD;
          pend_start_nx = 1'b0;
        end else if (ld_start) begin
          pend_start_nx = 1'b1;
        end
      end
      default: state_nx = ST_LOAD;
    endcase
  end

  // FSM outputs: fetches are only offered in RUN with no re-load pending.
  always_comb begin
    busy        = (state == ST_LOAD);
    fetch_ready = (state == ST_RUN) && !pend_start;
  end

  // Sticky loader error; a new error in the same cycle as ld_start wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_err <= 1'b0;
    end else if (ld_bad) begin
      ld_err <= 1'b1;
    end else if (ld_start) begin
      ld_err <= 1'b0;
    end
  end

  instr_mem_array #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_ok),
    .wr_idx  (ld_addr[IDX_W+1:2]),
    .wr_data (ld_data),
    .rd_en   (accept),
    .rd_idx  (pc[IDX_W+1:2]),
    .rd_data (rd_data_p0)
  );

  // Stage p0: fault code registered alongside the RAM read; holds between fetches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p0 <= 1'b0;
      flt_p0 <= FLT_OK;
    end else begin
      vld_p0 <= accept;
      if (accept) flt_p0 <= fetch_fault(pc);
    end
  end

  assign inst_p0 = (flt_p0 != FLT_OK) ? NOP_WORD : rd_data_p0;

  generate
    if (READ_LAT == 1) begin : g_lat1
      assign vld_tail  = 1'b0;
      assign rsp_valid = vld_p0;
      assign rsp_inst  = inst_p0;
      assign rsp_fault = flt_p0;
    end else begin : g_latn
      localparam int XS = READ_LAT - 1;
      logic        vld_px  [XS];
      logic [31:0] inst_px [XS];
      logic [1:0]  flt_px  [XS];

      // Stages p1..: valid shifts every cycle, payload moves only with valid.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < XS; i++) begin
            vld_px[i]  <= 1'b0;
            inst_px[i] <= '0;
            flt_px[i]  <= FLT_OK;
          end
        end else begin
          vld_px[0] <= vld_p0;
          if (vld_p0) begin
            inst_px[0] <= inst_p0;
            flt_px[0]  <= flt_p0;
          end
          for (int i = 1; i < XS; i++) begin
            vld_px[i] <= vld_px[i-1];
            if (vld_px[i-1]) begin
              inst_px[i] <= inst_px[i-1];
              flt_px[i]  <= flt_px[i-1];
            end
          end
        end
      end

      // Any response still travelling through the extra stages.
      always_comb begin
        vld_tail = 1'b0;
        for (int i = 0; i < XS; i++) vld_tail = vld_tail | vld_px[i];
      end

      assign rsp_valid = vld_px[XS-1];
      assign rsp_inst  = inst_px[XS-1];
      assign rsp_fault = flt_px[XS-1];
    end
  endgenerate

endmodule
